item_dispense: RTL

- Consumer end of the selection interface: accepts a registered selection (item, quantity, selection_done pulse) and checks it against a per-item stock table.
- Drives the dispense motor one unit at a time through a req/ack handshake.
- Returns a dispense_valid pulse that closes the transaction, which clears the selection stage.
- Sits between the selection stage and the motor driver; also owns restocking.

---
 rtl/vm_pkg.sv | 23 ++
 rtl/vm_stock_ram.sv | 48 ++++
 rtl/item_dispense.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/vm_pkg.sv
// rtl/vm_pkg.sv - shared widths, FSM states and error codes for the vending datapath
package vm_pkg;

    localparam int ITEM_ADDR_W   = 10;
    localparam int NO_ITEMS_W    = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_CHECK  = 3'd2,
        S_REQ    = 3'd3,
        S_GAP    = 3'd4,
        S_DONE   = 3'd5,
        S_REJECT = 3'd6
    } state_e;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_ZERO_QTY = 3'd1;
    localparam logic [2:0] ERR_BAD_ITEM = 3'd2;
    localparam logic [2:0] ERR_NO_STOCK = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd4;

endpackage

// File: rtl/vm_stock_ram.sv
// rtl/vm_stock_ram.sv - per-item stock table, one sync read port, one decrement/restock write port
module vm_stock_ram #(
    parameter int AW    = 10,
    parameter int DW    = 8,
    parameter int DEPTH = 1024,
    parameter int INIT  = 10
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    input  logic          wr_en,
    input  logic          wr_dec,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_qty
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rd_data_q;
    logic [DW-1:0] wr_cur;
    logic [DW:0]   wr_sum;
    logic [DW-1:0] wr_next;

    // Read-modify-write value: decrement by one unit, or saturating add for restock
    always_comb begin
        wr_cur  = (int'(wr_addr) < DEPTH) ? mem_q[wr_addr] : '0;
        wr_sum  = {1'b0, wr_cur} + {1'b0, wr_qty};
        wr_next = wr_dec ? (wr_cur - 1'b1) : (wr_sum[DW] ? '1 : wr_sum[DW-1:0]);
    end

    // Storage array: every entry returns to INIT on reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= DW'(INIT);
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_next;
        end
    end

    // Registered read port; out-of-range addresses read as zero
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rd_data_q <= '0;
        else       rd_data_q <= (int'(rd_addr) < DEPTH) ? mem_q[rd_addr] : '0;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/item_dispense.sv
// rtl/item_dispense.sv - validates a selection against stock and drives the motor unit by unit
module item_dispense
    import vm_pkg::*;
#(
    parameter int item_addr      = ITEM_ADDR_W,
    parameter int no_items_addr  = NO_ITEMS_W,
    parameter int NUM_ITEMS      = 1024,
    parameter int INIT_STOCK     = 10,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     selection_done,
    input  logic [item_addr-1:0]     item_selected,
    input  logic [no_items_addr-1:0] no_items_selected,
    input  logic                     restock_valid,
    input  logic [item_addr-1:0]     restock_item,
    input  logic [no_items_addr-1:0] restock_qty,
    output logic                     restock_ready,
    input  logic                     motor_ack,
    output logic                     motor_req,
    output logic [item_addr-1:0]     motor_item,
    output logic                     dispense_valid,
    output logic                     dispense_error,
    output logic [2:0]               error_code,
    output logic [no_items_addr-1:0] dispensed_count,
    output logic                     busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_e                   state_q, state_d;
    logic [item_addr-1:0]     item_q, item_d;
    logic [no_items_addr-1:0] qty_q, qty_d;
    logic [no_items_addr-1:0] remaining_q, remaining_d;
    logic [no_items_addr-1:0] count_q, count_d;
    logic [2:0]               err_q, err_d;
    logic [TW-1:0]            tmo_q, tmo_d;

    logic [no_items_addr-1:0] stock_rd;
    logic                     wr_en, wr_dec;
    logic [item_addr-1:0]     wr_addr;
    logic [no_items_addr-1:0] wr_qty;

    vm_stock_ram #(
        .AW    (item_addr),
        .DW    (no_items_addr),
        .DEPTH (NUM_ITEMS),
        .INIT  (INIT_STOCK)
    ) u_ram (
        .clk     (clk),
        .rstn    (rstn),
        .rd_addr (item_q),
        .rd_data (stock_rd),
        .wr_en   (wr_en),
        .wr_dec  (wr_dec),
        .wr_addr (wr_addr),
        .wr_qty  (wr_qty)
    );

    // State and transaction registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            item_q      <= '0;
            qty_q       <= '0;
            remaining_q <= '0;
            count_q     <= '0;
            err_q       <= ERR_NONE;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            item_q      <= item_d;
            qty_q       <= qty_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
        end
    end

    // Next-state, stock write arbitration (restock only in IDLE, decrement only in REQ)
    always_comb begin
        state_d     = state_q;
        item_d      = item_q;
        qty_d       = qty_q;
        remaining_d = remaining_q;
        count_d     = count_q;
        err_d       = err_q;
        tmo_d       = tmo_q;
        wr_en       = 1'b0;
        wr_dec      = 1'b0;
        wr_addr     = restock_item;
        wr_qty      = restock_qty;

        if (state_q == S_IDLE && restock_valid && int'(restock_item) < NUM_ITEMS) begin
            wr_en = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (selection_done) begin
                    item_d  = item_selected;
                    qty_d   = no_items_selected;
                    count_d = '0;
                    err_d   = ERR_NONE;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: state_d = S_CHECK;
            S_CHECK: begin
                if (qty_q == '0) begin
                    err_d   = ERR_ZERO_QTY;
                    state_d = S_REJECT;
                end else if (int'(item_q) >= NUM_ITEMS) begin
                    err_d   = ERR_BAD_ITEM;
                    state_d = S_REJECT;
                end else if (stock_rd < qty_q) begin
                    err_d   = ERR_NO_STOCK;
                    state_d = S_REJECT;
                end else begin
                    remaining_d = qty_q;
                    tmo_d       = '0;
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                if (motor_ack) begin
                    wr_en       = 1'b1;
                    wr_dec      = 1'b1;
                    wr_addr     = item_q;
                    remaining_d = remaining_q - 1'b1;
                    count_d     = count_q + 1'b1;
                    state_d     = S_GAP;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = S_REJECT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_GAP: begin
                tmo_d   = '0;
                state_d = (remaining_q == '0) ? S_DONE : S_REQ;
            end
            S_DONE:   state_d = S_IDLE;
            S_REJECT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign restock_ready   = (state_q == S_IDLE);
    assign motor_req       = (state_q == S_REQ);
    assign motor_item      = item_q;
    assign dispense_valid  = (state_q == S_DONE) || (state_q == S_REJECT);
    assign dispense_error  = (state_q == S_REJECT);
    assign error_code      = err_q;
    assign dispensed_count = count_q;
    assign busy            = (state_q != S_IDLE);

endmodule
